// File: rtl/prog_loader.sv
// prog_loader: byte-stream boot loader that writes framed 32-bit words into
// instruction or data memory and holds the core in reset until a good frame.
module prog_loader #(
  parameter int          ADDR_W = 10,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              inst_we,
  output logic              data_we,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);
  typedef enum logic [2:0] {IDLE, TARGET, LEN_LO, LEN_HI, DATA, CSUM} state_t;
  state_t              state_q, state_d;
  logic                tgt_q, tgt_d;
  logic [15:0]         cnt_q, cnt_d, widx_q, widx_d;
  logic [1:0]          lane_q, lane_d;
  logic [23:0]         part_q, part_d;
  logic [7:0]          csum_q, csum_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                iwe_q, iwe_d, dwe_q, dwe_d;
  logic                hold_q, hold_d, done_q, done_d, err_q, err_d;
  assign in_ready  = 1'b1;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign inst_we   = iwe_q;
  assign data_we   = dwe_q;
  assign core_hold = hold_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    lane_d  = lane_q;
    part_d  = part_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    iwe_d   = 1'b0;
    dwe_d   = 1'b0;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    if (in_valid) begin
      case (state_q)
        IDLE: if (in_data == MAGIC) begin
          state_d = TARGET;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end
        TARGET: if (in_data[7:1] == 7'd0) begin
          tgt_d   = in_data[0];
          state_d = LEN_LO;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
        LEN_LO: begin
          cnt_d[7:0] = in_data;
          state_d    = LEN_HI;
        end
        LEN_HI: begin
          cnt_d[15:8] = in_data;
          widx_d      = 16'd0;
          lane_d      = 2'd0;
          csum_d      = 8'd0;
          state_d     = ({in_data, cnt_q[7:0]} != 16'd0) ? DATA : CSUM;
        end
        DATA: begin
          csum_d = csum_q ^ in_data;
          lane_d = lane_q + 2'd1;
          if (lane_q != 2'd3) part_d[{lane_q, 3'b000} +: 8] = in_data;
          else begin
            // word index wraps silently into the memory's address range
            wdata_d = {in_data, part_q};
            addr_d  = {widx_q[ADDR_W-3:0], 2'b00};
            iwe_d   = !tgt_q;
            dwe_d   = tgt_q;
            widx_d  = widx_q + 16'd1;
            if (widx_q == cnt_q - 16'd1) state_d = CSUM;
          end
        end
        CSUM: begin
          state_d = IDLE;
          if (in_data == csum_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= 1'b0;
      cnt_q   <= 16'd0;
      widx_q  <= 16'd0;
      lane_q  <= 2'd0;
      part_q  <= 24'd0;
      csum_q  <= 8'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      iwe_q   <= 1'b0;
      dwe_q   <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      lane_q  <= lane_d;
      part_q  <= part_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      iwe_q   <= iwe_d;
      dwe_q   <= dwe_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader, one default instance and
// one with ADDR_W=4 sharing the same stream to exercise address wrap.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready, inst_we, data_we, core_hold, load_done, load_err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        s_ready, s_iwe, s_dwe, s_hold, s_done, s_err;
  logic [3:0]  s_addr;
  logic [31:0] s_wdata;
  logic [43:0] exp_q[$];
  logic [43:0] exp_s[$];
  int          n_chk = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  prog_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .inst_we(inst_we), .data_we(data_we),
    .core_hold(core_hold), .load_done(load_done), .load_err(load_err)
  );
  prog_loader #(.ADDR_W(4)) dut_s (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(s_ready),
    .mem_addr(s_addr), .mem_wdata(s_wdata), .inst_we(s_iwe), .data_we(s_dwe),
    .core_hold(s_hold), .load_done(s_done), .load_err(s_err)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push_w(input logic inst, input logic [9:0] addr, input logic [31:0] w);
    exp_q.push_back({inst, !inst, addr, w});
    exp_s.push_back({inst, !inst, addr, w});
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (inst_we || data_we) begin
      if (exp_q.size() == 0) chk("unexp_we", {inst_we, data_we, mem_addr, mem_wdata}, 0);
      else chk("wr", {inst_we, data_we, mem_addr, mem_wdata}, exp_q.pop_front());
    end
    if (s_iwe || s_dwe) begin
      if (exp_s.size() == 0) chk("unexp_we_s", {s_iwe, s_dwe, s_addr, s_wdata}, 0);
      else begin
        logic [43:0] e;
        e = exp_s.pop_front();
        chk("wr_s", {s_iwe, s_dwe, s_addr, s_wdata}, {e[43:42], e[35:32], e[31:0]});
      end
    end
  end
  initial begin
    logic [7:0] ib[13];
    logic [7:0] b, x;
    ib = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
           8'hB3, 8'h05, 8'hA5, 8'h00, 8'h15};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {in_ready, mem_addr, mem_wdata, inst_we, data_we, core_hold, load_done, load_err},
        {1'b1, 10'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_w(1'b1, 10'd0, 32'h00100513);
    push_w(1'b1, 10'd4, 32'h00A505B3);
    for (int i = 0; i < 12; i++) send(ib[i], 0);
    chk("inst_hold_pre", core_hold, 1);
    send(ib[12], 0);
    chk("inst_done", {load_done, load_err, core_hold}, 3'b100);
    push_w(1'b0, 10'd0, 32'hDEADBEEF);
    send(8'hA5, 0);
    chk("magic_hold", {core_hold, load_done}, 2'b10);
    send(8'h01, 0); send(8'h01, 0); send(8'h00, 0);
    send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0);
    send(8'h22, 0);
    chk("data_done", {load_done, load_err, core_hold}, 3'b100);
    push_w(1'b0, 10'd0, 32'hDEADBEEF);
    send(8'hA5, 0); send(8'h01, 0); send(8'h01, 0); send(8'h00, 0);
    send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0);
    send(8'h23, 0);
    chk("bad_csum", {load_done, load_err, core_hold}, 3'b011);
    send(8'h00, 0); send(8'hFF, 0);
    chk("garbage_ign", {load_done, load_err, core_hold}, 3'b011);
    send(8'hA5, 0);
    chk("magic_clr", {load_done, load_err, core_hold}, 3'b001);
    send(8'h07, 0);
    chk("bad_tgt", {load_done, load_err, core_hold}, 3'b011);
    send(8'hA5, 3); send(8'h00, 3); send(8'h00, 3); send(8'h00, 3);
    chk("gap_hold", core_hold, 1);
    send(8'h00, 3);
    chk("zero_cnt", {load_done, load_err, core_hold}, 3'b100);
    send(8'hA5, 0); send(8'h00, 0); send(8'h02, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h05, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst", {mem_addr, mem_wdata, inst_we, data_we, core_hold, load_done, load_err},
        {10'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    send(8'h10, 0); send(8'h00, 0);
    chk("post_rst_idle", {load_done, load_err, core_hold}, 3'b001);
    x = 8'd0;
    for (int i = 0; i < 5; i++)
      push_w(1'b0, 10'(i * 4), {8'(16 * i + 4), 8'(16 * i + 3), 8'(16 * i + 2), 8'(16 * i + 1)});
    send(8'hA5, 0); send(8'h01, 0); send(8'h05, 0); send(8'h00, 0);
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 4; k++) begin
        b = 8'(16 * i + k + 1);
        x = x ^ b;
        send(b, 0);
      end
    send(x, 0);
    chk("wrap_done", {load_done, s_done, s_hold}, 3'b110);
    repeat (3) @(posedge clk);
    #1;
    chk("q_empty", 64'(exp_q.size()), 0);
    chk("q_empty_s", 64'(exp_s.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
